// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, bit-timer width and the
// clocks-per-bit computation used by both the transmitter and the receiver.
// Optional feature macro: UART_TX_PARITY_EN (adds the TX_PARITY_BIT state).
package uart_pkg;

  localparam int BAUD_CNT_W = 18;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY_BIT = 3'd3,
`endif
    TX_STOP_BIT   = 3'd4
  } uart_state_e;

  // Integer division on purpose: the line rate is truncated, never rounded.
  function automatic int clocksPerBit(input int clkHz, input int baudRate);
    return clkHz / baudRate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request handshake and serial-line status of the UART transmitter.
// The master drives a byte request; the slave (the transmitter) reports status.
interface uart_tx_if;

  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Ready;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  modport master (
    output i_TX_DV,
    output i_TX_Byte,
    input  o_TX_Ready,
    input  o_TX_Active,
    input  o_TX_Serial,
    input  o_TX_Done
  );

  modport slave (
    input  i_TX_DV,
    input  i_TX_Byte,
    output o_TX_Ready,
    output o_TX_Active,
    output o_TX_Serial,
    output o_TX_Done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit timer: counts CLOCKS_PER_BIT cycles per bit and raises a one-cycle
// tick on the last cycle of each bit. Restart holds the count at zero so the
// first bit of a frame always starts from a clean count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [BAUD_CNT_W-1:0] LAST_COUNT = BAUD_CNT_W'(CLOCKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] count_q;

  assign tick_o = (count_q == LAST_COUNT);

  // Free-running bit counter that wraps on every bit end or on restart.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (restart_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, one stop bit, with a one-byte
// holding register so a second byte can be queued while a frame is on the line.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, 11-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK       = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic    i_Clock,
  input  logic    i_Rst_n,
  uart_tx_if.slave tx
);

  localparam int CLOCKS_PER_BIT = clocksPerBit(CLK, BAUD_RATE);

  uart_state_e state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        holdFull_q, holdFull_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        bitTick;
  logic        baudRestart;

  assign baudRestart = (state_q == IDLE);

  uart_baud_gen #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud_gen (
    .clk_i    (i_Clock),
    .rst_ni   (i_Rst_n),
    .restart_i(baudRestart),
    .tick_o   (bitTick)
  );

  assign tx.o_TX_Ready  = !holdFull_q;
  assign tx.o_TX_Active = active_q;
  assign tx.o_TX_Serial = serial_q;
  assign tx.o_TX_Done   = (state_q == TX_STOP_BIT) && bitTick;

  // State register; reset aborts any frame, empties the holding register and
  // forces the line high at once.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next state: the line value for the coming cycle is decided here and
  // registered, so the serial output never sees the inputs combinationally.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    shift_d    = shift_q;
    bitIdx_d   = bitIdx_q;
    serial_d   = serial_q;
    active_d   = active_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // A request is taken only when the holding register is empty; the
    // register is only ever emptied while full, so the two never collide.
    if (tx.i_TX_DV && !holdFull_q) begin
      hold_d     = tx.i_TX_Byte;
      holdFull_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        bitIdx_d = '0;
        if (holdFull_q) begin
          shift_d    = hold_q;
          holdFull_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^hold_q;
`endif
          state_d    = TX_START_BIT;
          serial_d   = 1'b0;
          active_d   = 1'b1;
        end
      end

      TX_START_BIT: begin
        if (bitTick) begin
          state_d  = TX_DATA_BITS;
          bitIdx_d = '0;
          serial_d = shift_q[0];
        end
      end

      TX_DATA_BITS: begin
        if (bitTick) begin
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = TX_PARITY_BIT;
            serial_d = parity_q;
`else
            state_d  = TX_STOP_BIT;
            serial_d = 1'b1;
`endif
          end else begin
            serial_d = shift_q[bitIdx_q + 3'd1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        if (bitTick) begin
          state_d  = TX_STOP_BIT;
          serial_d = 1'b1;
        end
      end
`endif

      TX_STOP_BIT: begin
        if (bitTick) begin
          if (holdFull_q) begin
            shift_d    = hold_q;
            holdFull_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^hold_q;
`endif
            bitIdx_d   = '0;
            state_d    = TX_START_BIT;
            serial_d   = 1'b0;
            active_d   = 1'b1;
          end else begin
            state_d  = IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx at 50 MHz / 115200 baud (434 clocks per bit).
// Build with UART_TX_PARITY_EN defined to exercise the parity frame as well.
module tb_uart_tx;

  localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk;
  logic rstN;
  int   vectors;
  int   miscompares;

  uart_tx_if txIf ();

  uart_tx #(
    .CLK      (50_000_000),
    .BAUD_RATE(115200)
  ) dut (
    .i_Clock(clk),
    .i_Rst_n(rstN),
    .tx     (txIf)
  );

  // Free-running 50 MHz clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Issue one request at a negedge; the byte must be accepted and Ready must
  // drop on the following cycle.
  task automatic sendByte(input logic [7:0] b);
    vectors++;
    if (txIf.o_TX_Ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_before_send: got %b, required 1", txIf.o_TX_Ready);
    end
    txIf.i_TX_DV   = 1'b1;
    txIf.i_TX_Byte = b;
    @(negedge clk);
    txIf.i_TX_DV   = 1'b0;
    vectors++;
    if (txIf.o_TX_Ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_cleared: got %b, required 0", txIf.o_TX_Ready);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; checks every cycle of
  // the frame and returns at the negedge of the first cycle after it.
  task automatic checkFrame(input logic [7:0] b, input logic par, input string tag);
    logic [10:0] frameBits;
    int bad;
    int inactive;
    int doneCnt;
    int donePos;
    frameBits = {1'b1, par, b, 1'b0};
`ifndef UART_TX_PARITY_EN
    frameBits = {par, 1'b1, b, 1'b0};
`endif
    inactive = 0;
    doneCnt  = 0;
    donePos  = -1;
    for (int k = 0; k < FRAME_BITS; k++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (txIf.o_TX_Serial !== frameBits[k]) bad++;
        if (txIf.o_TX_Active !== 1'b1) inactive++;
        if (txIf.o_TX_Done === 1'b1) begin
          doneCnt++;
          donePos = k * CPB + c + 1;
        end
        @(negedge clk);
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("[TB] FAIL %s_bit%0d: line wrong on %0d of %0d cycles, required %b",
                 tag, k, bad, CPB, frameBits[k]);
      end
    end
    vectors++;
    if (inactive != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_active: low on %0d frame cycles, required 0", tag, inactive);
    end
    vectors++;
    if (doneCnt != 1 || donePos != FRAME_BITS * CPB) begin
      miscompares++;
      $display("[TB] FAIL %s_done: %0d pulses, last at cycle %0d, required 1 at %0d",
               tag, doneCnt, donePos, FRAME_BITS * CPB);
    end
  endtask

  // Watch an idle line for a number of cycles: high, inactive, ready.
  task automatic checkIdle(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      if (txIf.o_TX_Serial !== 1'b1 || txIf.o_TX_Active !== 1'b0 ||
          txIf.o_TX_Ready !== 1'b1 || txIf.o_TX_Done !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_idle: %0d of %0d cycles not idle, required 0", tag, bad, cycles);
    end
  endtask

  task automatic test_reset();
    rstN           = 1'b0;
    txIf.i_TX_DV   = 1'b0;
    txIf.i_TX_Byte = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({txIf.o_TX_Serial, txIf.o_TX_Ready, txIf.o_TX_Active, txIf.o_TX_Done} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got ser/rdy/act/done=%b%b%b%b, required 1100",
               txIf.o_TX_Serial, txIf.o_TX_Ready, txIf.o_TX_Active, txIf.o_TX_Done);
    end
    rstN = 1'b1;
    @(negedge clk);
    checkIdle(20, "post_reset");
  endtask

  task automatic test_single_byte();
    sendByte(8'hA5);
    vectors++;
    if (txIf.o_TX_Serial !== 1'b1 || txIf.o_TX_Active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_latency: start bit one cycle early, ser=%b act=%b, required 1/0",
               txIf.o_TX_Serial, txIf.o_TX_Active);
    end
    @(negedge clk);
    checkFrame(8'hA5, 1'b0, "A5");
    checkIdle(50, "A5_after");
  endtask

  task automatic test_back_to_back();
    sendByte(8'h55);
    @(negedge clk);
    fork
      checkFrame(8'h55, 1'b0, "b2b_55");
      begin
        repeat (100) @(negedge clk);
        sendByte(8'h0F);
      end
    join
    checkFrame(8'h0F, 1'b0, "b2b_0F");
    checkIdle(50, "b2b_after");
  endtask

  task automatic test_drop_while_busy();
    sendByte(8'h33);
    @(negedge clk);
    fork
      checkFrame(8'h33, 1'b0, "drop_33");
      begin
        repeat (200) @(negedge clk);
        sendByte(8'h0F);
        repeat (100) @(negedge clk);
        vectors++;
        if (txIf.o_TX_Ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL busy_ready: got %b, required 0", txIf.o_TX_Ready);
        end
        txIf.i_TX_DV   = 1'b1;
        txIf.i_TX_Byte = 8'hFF;
        @(negedge clk);
        txIf.i_TX_DV   = 1'b0;
      end
    join
    checkFrame(8'h0F, 1'b0, "drop_0F");
    checkIdle(1000, "drop_after");
  endtask

  task automatic test_reset_midframe();
    sendByte(8'h3C);
    @(negedge clk);
    vectors++;
    if (txIf.o_TX_Serial !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL 3C_start: got %b, required 0", txIf.o_TX_Serial);
    end
    repeat (49) @(negedge clk);
    sendByte(8'h81);
    repeat (4 * CPB + 200 - 51) @(negedge clk);
    vectors++;
    if (txIf.o_TX_Serial !== 1'b1 || txIf.o_TX_Active !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL 3C_bit3: ser=%b act=%b, required 1/1", txIf.o_TX_Serial, txIf.o_TX_Active);
    end
    #3 rstN = 1'b0;
    #1;
    vectors++;
    if ({txIf.o_TX_Serial, txIf.o_TX_Ready, txIf.o_TX_Active, txIf.o_TX_Done} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset: got ser/rdy/act/done=%b%b%b%b, required 1100",
               txIf.o_TX_Serial, txIf.o_TX_Ready, txIf.o_TX_Active, txIf.o_TX_Done);
    end
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkIdle(2 * FRAME_BITS * CPB, "midframe_after");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    sendByte(8'hA5);
    @(negedge clk);
    checkFrame(8'hA5, 1'b0, "par_A5");
    checkIdle(20, "par_A5_after");
    sendByte(8'h07);
    @(negedge clk);
    checkFrame(8'h07, 1'b1, "par_07");
    checkIdle(20, "par_07_after");
  endtask
`endif

  // Scenario sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    $display("[TB] uart_tx directed bench, %0d-bit frames", FRAME_BITS);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_drop_while_busy();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have port i_Clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_TX_DV, input, 1, one-cycle request to send i_TX_Byte.
REQ-006 SHALL have port i_TX_Byte, input, 8, byte to transmit, sampled only when i_TX_DV=1 and o_TX_Ready=1.
REQ-007 SHALL have port o_TX_Ready, output, 1, high when the holding register is empty and a request will be accepted.
REQ-008 SHALL have port o_TX_Active, output, 1, high while a frame is on the line.
REQ-009 SHALL have port o_TX_Serial, output, 1, serial line; idles high.
REQ-010 SHALL have port o_TX_Done, output, 1, one-cycle pulse at the end of each frame's stop bit.

Function
REQ-011 SHALL use CLOCKS_PER_BIT = CLK/BAUD_RATE (integer division); every bit SHALL last exactly CLOCKS_PER_BIT cycles.
REQ-012 SHALL contain a one-byte holding register; an accepted request writes it and clears o_TX_Ready on the next cycle.
REQ-013 SHALL ignore i_TX_DV while o_TX_Ready=0, leaving the holding register and i_TX_Byte sampling unaffected.
REQ-014 SHALL implement states IDLE, TX_START_BIT, TX_DATA_BITS, TX_PARITY_BIT (macro only), TX_STOP_BIT.
REQ-015 IDLE: o_TX_Serial=1 and o_TX_Active=0; when the holding register is full, SHALL move it into the shift register, set it empty, and enter TX_START_BIT.
REQ-016 The first start-bit cycle (o_TX_Serial=0, o_TX_Active=1) SHALL occur two cycles after the accepting i_TX_DV cycle when idle.
REQ-017 TX_DATA_BITS SHALL send 8 bits LSB first, using a 3-bit index that wraps after bit 7.
REQ-018 TX_STOP_BIT SHALL drive 1; on its last cycle it SHALL pulse o_TX_Done, then go to TX_START_BIT if the holding register is full (zero idle gap), otherwise IDLE.
REQ-019 A request accepted during a frame SHALL be sent immediately after that frame; frame order SHALL equal acceptance order.
REQ-020 An i_TX_DV in the same cycle the holding register is emptied SHALL be ignored; o_TX_Ready is the sole acceptance indicator.
REQ-021 o_TX_Serial SHALL be driven from a register with no combinational path from inputs.

Reset
REQ-022 While i_Rst_n=0: state=IDLE, counters=0, holding register empty, o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with the line high, and discard any held byte.

Configuration
REQ-024 SHALL use macro UART_TX_PARITY_EN; when defined, an even-parity bit (XOR of the 8 data bits) is sent in TX_PARITY_BIT between data and stop, for an 11-bit frame.
REQ-025 Without UART_TX_PARITY_EN, SHALL omit TX_PARITY_BIT and its logic, for a 10-bit frame (8N1).

Structure
REQ-026 SHALL take state encodings and the CLOCKS_PER_BIT computation from shared package uart_pkg, which the receiver also uses.
REQ-027 SHALL isolate bit timing in sub-module uart_baud_gen (counter width 18, restartable, one-cycle bit-end tick).

Verification (CLK=50_000_000, BAUD_RATE=115200, CLOCKS_PER_BIT=434)
REQ-028 Send 0xA5 from idle -> line 0 for 434 cycles, then 1,0,1,0,0,1,0,1 at 434 cycles each, then 1 for 434 cycles; o_TX_Done pulses once at cycle 4340 of the frame.
REQ-029 Send 0x55 then 0x0F back-to-back (second while first active) -> two contiguous frames with no idle cycles, order preserved, two o_TX_Done pulses 4340 cycles apart.
REQ-030 Assert i_TX_DV with 0xFF while o_TX_Ready=0 -> request dropped; only the previously accepted bytes appear on the line.
REQ-031 Assert i_Rst_n=0 during data bit 3 of 0x3C -> o_TX_Serial=1 within the same cycle; after release, no residual frame and o_TX_Ready=1.
REQ-032 With UART_TX_PARITY_EN, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; o_TX_Done at cycle 4774 of each frame.
